// File: rtl/max7219_pkg.sv
// Shared constants for the MAX7219 frame sequencer: register addresses, glyph codes, FSM states.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package max7219_pkg;

  // MAX7219 register addresses
  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  // Non-numeral glyph codes; 13-15 are blank
  localparam logic [3:0] GLYPH_HAPPY   = 4'd10;
  localparam logic [3:0] GLYPH_NEUTRAL = 4'd11;
  localparam logic [3:0] GLYPH_SAD     = 4'd12;

  // Power-up sequence length: shutdown, decode, intensity, scan limit, test off, normal op
  localparam int INIT_WORDS = 6;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_FRAME_REQ,
    S_SEND,
    S_GAP
  } state_t;

  // Command word for step idx of the power-up sequence
  function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] intensity);
    logic [15:0] w;
    case (idx)
      3'd0:    w = {4'h0, ADDR_SHUTDOWN,  8'h00};
      3'd1:    w = {4'h0, ADDR_DECODE,    8'h00};
      3'd2:    w = {4'h0, ADDR_INTENSITY, 4'h0, intensity};
      3'd3:    w = {4'h0, ADDR_SCANLIMIT, 8'h07};
      3'd4:    w = {4'h0, ADDR_TEST,      8'h00};
      3'd5:    w = {4'h0, ADDR_SHUTDOWN,  8'h01};
      default: w = {4'h0, ADDR_NOOP,      8'h00};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/max7219_glyph_rom.sv
// Glyph ROM: 8x8 bitmaps for numerals 0-9, happy, neutral, sad; codes 13-15 are blank.
// Latency: combinational.
// Backpressure: n/a.
module max7219_glyph_rom
  import max7219_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic [2:0] row_i,
  output logic [7:0] bits_o
);

  logic [63:0] glyph;
  logic [5:0]  lsb;

  // Whole bitmap per code, top row in the most significant byte
  always_comb begin
    case (code_i)
      4'd0:          glyph = 64'h3C666E7666663C00;
      4'd1:          glyph = 64'h183818181818_7E00;
      4'd2:          glyph = 64'h3C66060C30607E00;
      4'd3:          glyph = 64'h3C66061C06663C00;
      4'd4:          glyph = 64'h0C1C3C6C7E0C0C00;
      4'd5:          glyph = 64'h7E607C0606663C00;
      4'd6:          glyph = 64'h3C607C6666663C00;
      4'd7:          glyph = 64'h7E060C1830303000;
      4'd8:          glyph = 64'h3C66663C66663C00;
      4'd9:          glyph = 64'h3C66663E060C3800;
      GLYPH_HAPPY:   glyph = 64'h3C42A581A599423C;
      GLYPH_NEUTRAL: glyph = 64'h3C42A58181BD423C;
      GLYPH_SAD:     glyph = 64'h3C42A58199A5423C;
      default:       glyph = 64'h0;
    endcase
  end

  // Row 0 is the top byte, so the byte offset is (7 - row) * 8
  assign lsb    = {~row_i, 3'b000};
  assign bits_o = glyph[lsb +: 8];

endmodule

// File: rtl/max7219_frame_sequencer.sv
// Turns display code/enable into MAX7219 command words: 6-word init, then 8-row frames on change or refresh.
// Latency: 16 cycles from an input change (in idle) to the last row word accepted, with ready held high.
// Backpressure: word_data/word_valid held until word_ready; one idle cycle is always inserted between words.
module max7219_frame_sequencer
  import max7219_pkg::*;
#(
  parameter logic [3:0]  INTENSITY      = 4'h8,
  parameter int unsigned REFRESH_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  digit,
  input  logic        enable_display,
  output logic [15:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        busy
);

  localparam bit REFRESH_EN = (REFRESH_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = REFRESH_EN ? CNT_W'(REFRESH_CYCLES - 1) : '0;

  state_t            state_q;
  logic [2:0]        init_idx_q;
  logic [3:0]        row_q;
  logic              snap_en_q;
  logic [3:0]        snap_digit_q;
  logic              snap_vld_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       word_data_q;
  logic              word_valid_q;
  logic              busy_q;

  logic              xfer;
  logic              changed;
  logic              refresh_hit;
  logic [3:0]        rom_code;
  logic [2:0]        rom_row;
  logic              rom_en;
  logic [7:0]        rom_bits;
  logic [7:0]        row_bits_d;

  assign xfer        = word_valid_q && word_ready;
  // An unset snapshot always counts as changed, so the first frame after init is never skipped
  assign changed     = !snap_vld_q || ({enable_display, digit} != {snap_en_q, snap_digit_q});
  assign refresh_hit = REFRESH_EN && (cnt_q == CNT_MAX);

  // Row 1 is built from the live inputs while they are being latched; later rows use the snapshot
  always_comb begin
    rom_code = snap_digit_q;
    rom_row  = row_q[2:0] - 3'd1;
    rom_en   = snap_en_q;
    if (state_q == S_FRAME_REQ) begin
      rom_code = digit;
      rom_row  = 3'd0;
      rom_en   = enable_display;
    end
  end

  max7219_glyph_rom u_rom (
    .code_i (rom_code),
    .row_i  (rom_row),
    .bits_o (rom_bits)
  );

  assign row_bits_d = rom_en ? rom_bits : 8'h00;

  // Sequencer FSM; all outputs are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      init_idx_q   <= 3'd0;
      row_q        <= 4'd1;
      snap_en_q    <= 1'b0;
      snap_digit_q <= 4'hF;
      snap_vld_q   <= 1'b0;
      cnt_q        <= '0;
      word_data_q  <= 16'h0000;
      word_valid_q <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      case (state_q)
        S_INIT: begin
          if (!word_valid_q) begin
            word_valid_q <= 1'b1;
            word_data_q  <= init_word(init_idx_q, INTENSITY);
          end else if (xfer) begin
            word_valid_q <= 1'b0;
            if (init_idx_q == 3'(INIT_WORDS - 1)) begin
              state_q <= S_FRAME_REQ;
            end else begin
              init_idx_q <= init_idx_q + 3'd1;
            end
          end
        end
        S_IDLE: begin
          if (changed || refresh_hit) begin
            state_q <= S_FRAME_REQ;
            busy_q  <= 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_FRAME_REQ: begin
          snap_en_q    <= enable_display;
          snap_digit_q <= digit;
          snap_vld_q   <= 1'b1;
          row_q        <= 4'd1;
          cnt_q        <= '0;
          word_data_q  <= {4'h0, ADDR_DIGIT0, row_bits_d};
          word_valid_q <= 1'b1;
          state_q      <= S_SEND;
        end
        S_SEND: begin
          if (xfer) begin
            word_valid_q <= 1'b0;
            if (row_q == ADDR_DIGIT7) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              row_q   <= row_q + 4'd1;
              state_q <= S_GAP;
            end
          end
        end
        S_GAP: begin
          word_data_q  <= {4'h0, row_q, row_bits_d};
          word_valid_q <= 1'b1;
          state_q      <= S_SEND;
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  assign word_data  = word_data_q;
  assign word_valid = word_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_max7219_frame_sequencer.sv
// Bench for max7219_frame_sequencer: randomized display codes checked against a frame-level reference model.
// Latency: n/a.
// Backpressure: the bench drives word_ready, including stall windows.
module tb_max7219_frame_sequencer;

  localparam int REFRESH = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  digit = 4'd0;
  logic        enable_display = 1'b0;
  logic        word_ready = 1'b1;
  logic [15:0] word_data;
  logic        word_valid;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [15:0] got_w[$];
  int          got_c[$];

  logic [63:0] glyph_tab [13] = '{
    64'h3C666E7666663C00, 64'h1838181818187E00, 64'h3C66060C30607E00, 64'h3C66061C06663C00,
    64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00, 64'h3C607C6666663C00, 64'h7E060C1830303000,
    64'h3C66663C66663C00, 64'h3C66663E060C3800, 64'h3C42A581A599423C, 64'h3C42A58181BD423C,
    64'h3C42A58199A5423C};
  logic [15:0] init_tab [6] = '{16'h0C00, 16'h0900, 16'h0A08, 16'h0B07, 16'h0F00, 16'h0C01};

  max7219_frame_sequencer #(
    .INTENSITY      (4'h8),
    .REFRESH_CYCLES (REFRESH),
    .CNT_W          (20)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .digit          (digit),
    .enable_display (enable_display),
    .word_data      (word_data),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Expected row word: row address 1..8, glyph byte when enabled and code <= 12, else dark
  function automatic logic [15:0] exp_row(input logic en, input logic [3:0] d, input int r);
    logic [63:0] g;
    logic [7:0]  b;
    b = 8'h00;
    if (en && d <= 4'd12) begin
      g = glyph_tab[d];
      b = g[63 - 8 * (r - 1) -: 8];
    end
    return {4'h0, 4'(r), b};
  endfunction

  // Handshake monitor on the falling edge: records transfers and checks hold/gap rules
  logic        p_vld = 1'b0;
  logic        p_rdy = 1'b0;
  logic [15:0] p_dat = 16'h0;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_vld = 1'b0;
      p_rdy = 1'b0;
    end else begin
      if (p_vld && !p_rdy) begin
        checks++;
        if (word_valid !== 1'b1 || word_data !== p_dat) begin
          errors++;
          $display("FAIL hold: valid=%b data=%h, required valid=1 data=%h", word_valid, word_data, p_dat);
        end
      end
      if (p_vld && p_rdy) begin
        checks++;
        if (word_valid !== 1'b0) begin
          errors++;
          $display("FAIL gap: valid=%b right after a transfer, required 0", word_valid);
        end
      end
      if (word_valid && word_ready) begin
        got_w.push_back(word_data);
        got_c.push_back(cyc);
      end
      p_vld = word_valid;
      p_rdy = word_ready;
      p_dat = word_data;
    end
  end

  task automatic clear_log();
    got_w.delete();
    got_c.delete();
  endtask

  task automatic wait_words(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (got_w.size() < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (got_w.size() < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d words, required %0d", tag, got_w.size(), n);
    end
  endtask

  task automatic wait_row_valid(input int r, input string tag);
    int k;
    bit found;
    found = 1'b0;
    for (k = 0; k < 80; k++) begin
      @(posedge clk);
      #1;
      if (word_valid === 1'b1 && word_data[11:8] == 4'(r)) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: row %0d never became valid", tag, r);
    end
  endtask

  task automatic test_reset();
    logic [15:0] w;
    rst_n = 1'b0;
    word_ready = 1'b1;
    enable_display = 1'b0;
    digit = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    checks += 3;
    if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", word_valid); end
    if (word_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h, required 0000", word_data); end
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b, required 1", busy); end
    clear_log();
    rst_n = 1'b1;
    wait_words(14, 100, "init");
    for (int i = 0; i < 14; i++) begin
      w = (i < got_w.size()) ? got_w[i] : 16'hxxxx;
      checks++;
      if (i < 6) begin
        if (w !== init_tab[i]) begin errors++; $display("FAIL init_word%0d: got %h, required %h", i, w, init_tab[i]); end
      end else begin
        if (w !== exp_row(1'b0, 4'd0, i - 5)) begin
          errors++;
          $display("FAIL first_frame%0d: got %h, required %h", i - 5, w, exp_row(1'b0, 4'd0, i - 5));
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_frame: got %b, required 0", busy); end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (got_w.size() != 14) begin errors++; $display("FAIL quiet_after_init: got %0d words, required 14", got_w.size()); end
  endtask

  task automatic test_glyph_frames();
    logic       en;
    logic [3:0] d;
    logic [15:0] w;
    int t0;
    for (int p = 0; p < 6; p++) begin
      if (p == 0) begin
        en = 1'b1;
        d = 4'd7;
      end else begin
        en = ($urandom_range(0, 3) != 0);
        d = 4'($urandom_range(0, 15));
        if ({en, d} == {enable_display, digit}) d = d + 4'd1;
      end
      clear_log();
      t0 = cyc;
      enable_display = en;
      digit = d;
      wait_words(8, 60, "glyph");
      for (int r = 1; r <= 8; r++) begin
        w = (r <= got_w.size()) ? got_w[r - 1] : 16'hxxxx;
        checks++;
        if (w !== exp_row(en, d, r)) begin
          errors++;
          $display("FAIL glyph en=%0b code=%0d row%0d: got %h, required %h", en, d, r, w, exp_row(en, d, r));
        end
      end
      if (p == 0 && got_c.size() >= 8) begin
        checks++;
        if (got_c[7] - t0 != 16) begin errors++; $display("FAIL frame_latency: got %0d cycles, required 16", got_c[7] - t0); end
      end
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (got_w.size() != 8) begin errors++; $display("FAIL quiet_after_frame: got %0d words, required 8", got_w.size()); end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] d;
    logic [15:0] w;
    d = 4'($urandom_range(0, 12));
    if (d == 4'd5) d = 4'd6;
    if ({1'b1, d} == {enable_display, digit}) d = (d == 4'd12) ? 4'd0 : d + 4'd1;
    if (d == 4'd5) d = 4'd6;
    clear_log();
    enable_display = 1'b1;
    digit = d;
    wait_row_valid(3, "bp_row3");
    word_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (word_valid !== 1'b1 || word_data !== exp_row(1'b1, d, 3)) begin
        errors++;
        $display("FAIL stall%0d: valid=%b data=%h, required valid=1 data=%h", k, word_valid, word_data, exp_row(1'b1, d, 3));
      end
    end
    word_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (got_w.size() != 3) begin errors++; $display("FAIL stall_release: got %0d words, required 3", got_w.size()); end
    wait_words(8, 60, "bp_frame");
    for (int r = 1; r <= 8; r++) begin
      w = (r <= got_w.size()) ? got_w[r - 1] : 16'hxxxx;
      checks++;
      if (w !== exp_row(1'b1, d, r)) begin
        errors++;
        $display("FAIL bp_row%0d: got %h, required %h", r, w, exp_row(1'b1, d, r));
      end
    end
  endtask

  task automatic test_midframe_change();
    logic [15:0] w;
    logic [15:0] e;
    clear_log();
    enable_display = 1'b1;
    digit = 4'd5;
    wait_row_valid(4, "mid_row4");
    digit = 4'd9;
    wait_words(16, 120, "mid_frames");
    for (int i = 0; i < 16; i++) begin
      w = (i < got_w.size()) ? got_w[i] : 16'hxxxx;
      e = (i < 8) ? exp_row(1'b1, 4'd5, i + 1) : exp_row(1'b1, 4'd9, i - 7);
      checks++;
      if (w !== e) begin errors++; $display("FAIL mid_word%0d: got %h, required %h", i, w, e); end
    end
    if (got_c.size() >= 9) begin
      checks++;
      if (got_c[8] - got_c[7] != 3) begin
        errors++;
        $display("FAIL mid_followup: spacing %0d cycles, required 3", got_c[8] - got_c[7]);
      end
    end
  endtask

  task automatic test_refresh();
    logic [3:0] d;
    logic [15:0] w;
    d = 4'($urandom_range(0, 12));
    if (d == 4'd9) d = 4'd10;
    clear_log();
    digit = d;
    wait_words(16, 150, "refresh");
    for (int i = 0; i < 16; i++) begin
      w = (i < got_w.size()) ? got_w[i] : 16'hxxxx;
      checks++;
      if (w !== exp_row(1'b1, d, (i % 8) + 1)) begin
        errors++;
        $display("FAIL refresh_word%0d: got %h, required %h", i, w, exp_row(1'b1, d, (i % 8) + 1));
      end
    end
    if (got_c.size() >= 9) begin
      checks++;
      if (got_c[8] - got_c[7] != REFRESH + 2) begin
        errors++;
        $display("FAIL refresh_period: spacing %0d cycles, required %0d", got_c[8] - got_c[7], REFRESH + 2);
      end
    end
    clear_log();
    digit = 4'd13;
    wait_words(8, 60, "blank");
    for (int r = 1; r <= 8; r++) begin
      w = (r <= got_w.size()) ? got_w[r - 1] : 16'hxxxx;
      checks++;
      if (w !== {4'h0, 4'(r), 8'h00}) begin
        errors++;
        $display("FAIL blank_row%0d: got %h, required %h", r, w, {4'h0, 4'(r), 8'h00});
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [3:0] d;
    logic [15:0] w;
    logic [15:0] e;
    d = 4'($urandom_range(0, 12));
    clear_log();
    digit = d;
    wait_row_valid(5, "rst_row5");
    #2;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (word_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b, required 0", word_valid); end
    if (word_data !== 16'h0) begin errors++; $display("FAIL async_reset_data: got %h, required 0000", word_data); end
    if (busy !== 1'b1) begin errors++; $display("FAIL async_reset_busy: got %b, required 1", busy); end
    repeat (2) @(posedge clk);
    #1;
    clear_log();
    rst_n = 1'b1;
    wait_words(14, 100, "reinit");
    for (int i = 0; i < 14; i++) begin
      w = (i < got_w.size()) ? got_w[i] : 16'hxxxx;
      e = (i < 6) ? init_tab[i] : exp_row(1'b1, d, i - 5);
      checks++;
      if (w !== e) begin errors++; $display("FAIL reinit_word%0d: got %h, required %h", i, w, e); end
    end
  endtask

  initial begin
    test_reset();
    test_glyph_frames();
    test_backpressure();
    test_midframe_change();
    test_refresh();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
